// File: rtl/wisc_dmem_responder.sv
// wisc_dmem_responder
// -------------------
// Responder side of the data-memory request interface. This is a stalling,
// multi-cycle memory of 2^AW 16-bit words. It accepts one read or write
// request from the memory stage. Stall is held until the access completes.
// Done then pulses for one cycle, with the read data on DataOut.
//
// Handshake: a request (Rd or Wr) is held stable by the requester until
// Done. Stall=1 tells it to hold and freeze. Done=1 marks the single cycle
// in which DataOut is valid. The interface accepts no request in the Done
// cycle, so the earliest next request is accepted one cycle after Done.
//
// Optional build macro: DMEM_RAND_LAT_EN. When it is defined, an 8-bit LFSR
// randomises each request's latency in the range 1..LAT.
//
// Parameters:
//   AW  - word-address width (storage is 2^AW words)
//   LAT - access latency in cycles, 1..15
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   Rd, Wr    - read / write request (exactly one for a legal request)
//   Addr      - byte address; word index is Addr[AW:1]; Addr[0] must be 0
//   DataIn    - write data
//   DataOut   - read data, valid while Done=1 (0 for writes)
//   Done      - one-cycle completion pulse
//   Stall     - requester must hold its request
//   err       - pulses for each cycle an illegal request is presented
//   dbg_state - current FSM state (0=IDLE, 1=WAIT, 2=DONE)
module wisc_dmem_responder #(
    parameter int AW  = 10,
    parameter int LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [3:0]     cnt, cnt_nxt;
    logic [AW-1:0]  cap_idx;
    logic           cap_wr;
    logic [3:0]     eff_lat;
    logic           req_valid, req_illegal;
    logic           accept, finish;
    logic [AW-1:0]  rd_idx;
    logic           rd_is_read;
    logic [15:0]    mem [0:(1<<AW)-1];

    // High address bits are deliberately ignored, so addresses alias.
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, Addr[15:AW+1]};

    assign req_valid   = (Rd ^ Wr) & ~Addr[0];
    assign req_illegal = (Rd | Wr) & ~req_valid;

`ifdef DMEM_RAND_LAT_EN
    logic [7:0] lfsr;
    logic [7:0] lat_mod;

    assign lat_mod = lfsr % 8'(LAT);
    assign eff_lat = 4'(lat_mod) + 4'd1;

    // Fibonacci LFSR with taps 8,6,5,4. It advances once per accepted
    // request, so the latency sequence depends only on the request count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 8'hA5;
        end else if (accept) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end
`else
    assign eff_lat = 4'(LAT);
`endif

    // Next-state and output logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        Stall     = 1'b0;
        Done      = 1'b0;
        err       = 1'b0;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    Stall  = 1'b1;
                    if (eff_lat == 4'd1) begin
                        finish    = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        // The WAIT state covers cycles 1..eff_lat-1, which
                        // is eff_lat-1 cycles, so the count starts at
                        // eff_lat-2.
                        cnt_nxt   = eff_lat - 4'd2;
                        state_nxt = S_WAIT;
                    end
                end else if (req_illegal) begin
                    err = 1'b1;
                end
            end
            S_WAIT: begin
                Stall = 1'b1;
                if (cnt == 4'd0) begin
                    finish    = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_DONE: begin
                Done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // While reset is asserted, the outputs stay low even if the
        // requester drives a request, and nothing is accepted.
        if (!rst) begin
            Stall  = 1'b0;
            err    = 1'b0;
            accept = 1'b0;
            finish = 1'b0;
        end
    end

    // With a latency of 1, the read happens at the capture edge, so the
    // live request is used instead of the captured copy.
    assign rd_idx     = (state == S_IDLE) ? Addr[AW:1] : cap_idx;
    assign rd_is_read = (state == S_IDLE) ? Rd : ~cap_wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            cap_idx <= '0;
            cap_wr  <= 1'b0;
            DataOut <= 16'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                cap_idx <= Addr[AW:1];
                cap_wr  <= Wr;
            end
            if (finish) begin
                DataOut <= rd_is_read ? mem[rd_idx] : 16'd0;
            end else if (state == S_DONE) begin
                DataOut <= 16'd0;
            end
        end
    end

    // Storage is not reset. A write commits at its capture edge, so an
    // immediately following read of the same address sees the new data.
    always_ff @(posedge clk) begin
        if (accept && Wr) begin
            mem[Addr[AW:1]] <= DataIn;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_wisc_dmem_responder.sv
module tb_wisc_dmem_responder;

    localparam int AW  = 10;
    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic        Rd, Wr;
    logic [15:0] Addr, DataIn;
    logic [15:0] DataOut;
    logic        Done, Stall, err;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  m_lfsr;

    wisc_dmem_responder #(.AW(AW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .Rd(Rd), .Wr(Wr), .Addr(Addr), .DataIn(DataIn),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .err(err),
        .dbg_state(dbg_state)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference latency for the next accepted request.
    function automatic int next_lat();
        int l;
`ifdef DMEM_RAND_LAT_EN
        l = 1 + (int'(m_lfsr) % LAT);
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`else
        l = LAT;
`endif
        return l;
    endfunction

    // Drives one legal request, starting just after a rising edge (cycle 0).
    // It checks Stall, Done and err every cycle until Done. It then returns
    // just after the edge that follows Done, with the request still driven.
    task automatic run_req(input string tag, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [15:0] din,
                           input logic [15:0] rdata, input logic alt_en,
                           input logic [15:0] alt_addr);
        int lat;
        logic [15:0] exp;
        lat = next_lat();
        Rd = rd; Wr = wr; Addr = addr; DataIn = din;
        exp_q.push_back(wr ? 16'd0 : rdata);
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            check({tag, "_stall"}, 16'(Stall), 16'(k < lat));
            check({tag, "_done"}, 16'(Done), 16'(k == lat));
            check({tag, "_err"}, 16'(err), 16'd0);
            if (Done) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_qempty"}, 16'd1, 16'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check({tag, "_data"}, DataOut, exp);
                end
            end
            @(posedge clk); #1;
            // Changes made while the request is waiting must be ignored.
            if (alt_en && k == 0) begin
                Addr = alt_addr;
                DataIn = ~din;
            end
        end
        if (exp_q.size() != 0) begin
            check({tag, "_nodone"}, 16'(exp_q.size()), 16'd0);
            exp_q.delete();
        end
    endtask

    task automatic idle(input string tag, input int n);
        Rd = 1'b0; Wr = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check({tag, "_idle_stall"}, 16'(Stall), 16'd0);
            check({tag, "_idle_done"}, 16'(Done), 16'd0);
            check({tag, "_idle_err"}, 16'(err), 16'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic illegal(input string tag, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [15:0] din);
        Rd = rd; Wr = wr; Addr = addr; DataIn = din;
        repeat (2) begin
            @(negedge clk);
            check({tag, "_err"}, 16'(err), 16'd1);
            check({tag, "_stall"}, 16'(Stall), 16'd0);
            check({tag, "_done"}, 16'(Done), 16'd0);
            check({tag, "_state"}, 16'(dbg_state), 16'd0);
            @(posedge clk); #1;
        end
        Rd = 1'b0; Wr = 1'b0;
    endtask

    initial begin
        // The reset state is checked while a request is driven, to confirm
        // that the outputs stay low during reset.
        rst = 1'b0; Rd = 1'b1; Wr = 1'b0; Addr = 16'h0010; DataIn = 16'h0;
        m_lfsr = 8'hA5;
        #3;
        check("rst_stall", 16'(Stall), 16'd0);
        check("rst_done", 16'(Done), 16'd0);
        check("rst_err", 16'(err), 16'd0);
        check("rst_dout", DataOut, 16'd0);
        check("rst_state", 16'(dbg_state), 16'd0);
        Rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        idle("post_rst", 2);

        // Test 1: a write followed by a read back-to-back. The second request
        // is accepted in cycle LAT+1.
        run_req("t1_wr", 1'b0, 1'b1, 16'h0010, 16'h1234, 16'h0, 1'b0, 16'h0);
        run_req("t1_rd", 1'b1, 1'b0, 16'h0010, 16'h0, 16'h1234, 1'b0, 16'h0);
        idle("t1", 1);

        // Test 2: odd addresses are rejected, and the array is left unchanged.
        illegal("t2_rd_odd", 1'b1, 1'b0, 16'h0011, 16'h0);
        illegal("t2_wr_odd", 1'b0, 1'b1, 16'h0011, 16'hFFFF);
        run_req("t2_rd", 1'b1, 1'b0, 16'h0010, 16'h0, 16'h1234, 1'b0, 16'h0);
        idle("t2", 1);

        // Test 3: Rd and Wr asserted together are rejected, with no write.
        run_req("t3_wr", 1'b0, 1'b1, 16'h0020, 16'h1111, 16'h0, 1'b0, 16'h0);
        idle("t3a", 1);
        illegal("t3_both", 1'b1, 1'b1, 16'h0020, 16'h9999);
        run_req("t3_rd", 1'b1, 1'b0, 16'h0020, 16'h0, 16'h1111, 1'b0, 16'h0);
        idle("t3b", 1);

        // Test 4: an address change during WAIT is ignored.
        run_req("t4_wr0", 1'b0, 1'b1, 16'h0040, 16'hBEEF, 16'h0, 1'b0, 16'h0);
        run_req("t4_wr1", 1'b0, 1'b1, 16'h0042, 16'h7777, 16'h0, 1'b0, 16'h0);
        run_req("t4_rd", 1'b1, 1'b0, 16'h0040, 16'h0, 16'hBEEF, 1'b1, 16'h0042);
        idle("t4", 1);

        // Test 5: reset in cycle 2 of a write. The write stays committed.
        void'(next_lat());
        Rd = 1'b0; Wr = 1'b1; Addr = 16'h0030; DataIn = 16'hCAFE;
        @(negedge clk);
        check("t5_stall0", 16'(Stall), 16'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("t5_stall", 16'(Stall), 16'd0);
        check("t5_done", 16'(Done), 16'd0);
        check("t5_err", 16'(err), 16'd0);
        check("t5_dout", DataOut, 16'd0);
        check("t5_state", 16'(dbg_state), 16'd0);
        Wr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        m_lfsr = 8'hA5;
        idle("t5", LAT + 1);
        run_req("t5_rd", 1'b1, 1'b0, 16'h0030, 16'h0, 16'hCAFE, 1'b0, 16'h0);
        idle("t5b", 1);

        // Test 6: address aliasing above Addr[AW], then 8 back-to-back reads.
        run_req("t6_wr", 1'b0, 1'b1, 16'h0802, 16'h5A5A, 16'h0, 1'b0, 16'h0);
        run_req("t6_rd", 1'b1, 1'b0, 16'h0002, 16'h0, 16'h5A5A, 1'b0, 16'h0);
        for (int i = 0; i < 8; i++) begin
            run_req("t6_b2b", 1'b1, 1'b0, 16'h0002, 16'h0, 16'h5A5A, 1'b0, 16'h0);
        end
        idle("t6", 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
